// File: rtl/instr_reg_operand_select.sv
// Instruction register plus ALU-B operand and writeback multiplexers.
// Define IMM_SIGN_EXT_EN to sign-extend the immediate; otherwise it is zero-extended.
module instr_reg_operand_select #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               r_enable,
  input  logic [DATA_W-1:0]  data_in,
  output logic [INSTR_W-1:0] data_out,
  input  logic [DATA_W-1:0]  rb,
  input  logic               sel_mux1,
  output logic [DATA_W-1:0]  s1,
  input  logic [DATA_W-1:0]  mem_dout,
  input  logic [DATA_W-1:0]  soma,
  input  logic               sel_mux2,
  output logic [DATA_W-1:0]  s2
);

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  imm;
  logic               unused_hi;

  // Only the low word of the fetch bus carries the instruction.
  assign unused_hi = ^data_in[DATA_W-1:INSTR_W];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ir <= '0;
    end else if (r_enable) begin
      ir <= data_in[INSTR_W-1:0];
    end
  end

  assign data_out = ir;

`ifdef IMM_SIGN_EXT_EN
  assign imm = {{(DATA_W-INSTR_W){ir[INSTR_W-1]}}, ir};
`else
  assign imm = {{(DATA_W-INSTR_W){1'b0}}, ir};
`endif

  assign s1 = sel_mux1 ? rb : imm;
  assign s2 = sel_mux2 ? soma : mem_dout;

endmodule

// File: tb/tb_instr_reg_operand_select.sv
// Directed bench for instr_reg_operand_select.
// Build with or without IMM_SIGN_EXT_EN; expected immediates follow the macro.
module tb_instr_reg_operand_select;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        r_enable;
  logic [63:0] data_in;
  logic [31:0] data_out;
  logic [63:0] rb;
  logic        sel_mux1;
  logic [63:0] s1;
  logic [63:0] mem_dout;
  logic [63:0] soma;
  logic        sel_mux2;
  logic [63:0] s2;

  int checks = 0;
  int errors = 0;

`ifdef IMM_SIGN_EXT_EN
  localparam logic [63:0] EXP_NEG = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] EXP_MSB = 64'hFFFF_FFFF_8000_0001;
`else
  localparam logic [63:0] EXP_NEG = 64'h0000_0000_FFFF_FFFC;
  localparam logic [63:0] EXP_MSB = 64'h0000_0000_8000_0001;
`endif

  instr_reg_operand_select #(
    .DATA_W (64),
    .INSTR_W(32)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .r_enable(r_enable),
    .data_in (data_in),
    .data_out(data_out),
    .rb      (rb),
    .sel_mux1(sel_mux1),
    .s1      (s1),
    .mem_dout(mem_dout),
    .soma    (soma),
    .sel_mux2(sel_mux2),
    .s2      (s2)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sel1;
    logic [63:0] rb;
    logic        sel2;
    logic [63:0] mem;
    logic [63:0] soma;
    logic [63:0] exp_s1;
    logic [63:0] exp_s2;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Mux vectors, applied while IR holds 3
    vecs[0] = '{1'b0, 64'h2A, 1'b0, 64'h11, 64'h22,
                64'h3, 64'h11};
    vecs[1] = '{1'b1, 64'h2A, 1'b1, 64'h11, 64'h22,
                64'h2A, 64'h22};
    vecs[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                64'h8000_0000_0000_0000, 64'h1,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    vecs[3] = '{1'b0, 64'h0, 1'b1, 64'h0,
                64'h5555_AAAA_5555_AAAA,
                64'h3, 64'h5555_AAAA_5555_AAAA};
    vecs[4] = '{1'b1, 64'h0123_4567_89AB_CDEF, 1'b0,
                64'hFEDC_BA98_7654_3210, 64'h0,
                64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};

    reset_n  = 1'b0;
    r_enable = 1'b1;
    data_in  = 64'h5;
    rb       = '0;
    sel_mux1 = 1'b0;
    mem_dout = '0;
    soma     = '0;
    sel_mux2 = 1'b0;

    #2;
    tick();
    chk("reset_ir", {32'h0, data_out}, 64'h0);
    chk("reset_s1", s1, 64'h0);
    rb = 64'h77;
    sel_mux1 = 1'b1;
    #1;
    chk("reset_s1_rb", s1, 64'h77);

    reset_n = 1'b1;
    data_in = 64'hDEAD_BEEF_0000_0003;
    #1;
    chk("no_comb_path", {32'h0, data_out}, 64'h0);
    tick();
    chk("load_3", {32'h0, data_out}, 64'h3);

    r_enable = 1'b0;
    data_in  = 64'h7;
    tick();
    chk("hold_3a", {32'h0, data_out}, 64'h3);
    tick();
    chk("hold_3b", {32'h0, data_out}, 64'h3);

    for (int i = 0; i < 5; i++) begin
      sel_mux1 = vecs[i].sel1;
      rb       = vecs[i].rb;
      sel_mux2 = vecs[i].sel2;
      mem_dout = vecs[i].mem;
      soma     = vecs[i].soma;
      #1;
      chk($sformatf("vec%0d_s1", i), s1, vecs[i].exp_s1);
      chk($sformatf("vec%0d_s2", i), s2, vecs[i].exp_s2);
    end

    sel_mux1 = 1'b0;
    r_enable = 1'b1;
    data_in  = 64'h1234_5678_FFFF_FFFC;
    tick();
    chk("load_neg", {32'h0, data_out}, 64'hFFFF_FFFC);
    chk("imm_neg", s1, EXP_NEG);

    data_in = 64'h0000_0000_8000_0001;
    tick();
    chk("imm_msb", s1, EXP_MSB);

    data_in = 64'hFFFF_FFFF_7FFF_FFFF;
    tick();
    chk("imm_pos", s1, 64'h0000_0000_7FFF_FFFF);

    // Reset and load on the same edge: reset wins
    reset_n  = 1'b0;
    r_enable = 1'b1;
    data_in  = 64'h9;
    sel_mux2 = 1'b1;
    soma     = 64'h22;
    mem_dout = 64'h11;
    tick();
    chk("rst_wins", {32'h0, data_out}, 64'h0);
    chk("rst_s1_imm", s1, 64'h0);
    chk("rst_s2", s2, 64'h22);
    reset_n = 1'b1;
    tick();
    chk("release_9", {32'h0, data_out}, 64'h9);

    r_enable = 1'b0;
    reset_n  = 1'b0;
    tick();
    chk("rst_mid_hold", {32'h0, data_out}, 64'h0);
    reset_n = 1'b1;
    tick();
    chk("stay_0", {32'h0, data_out}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
